// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Purpose  : IF/MEM requester handshakes and unified memory bus bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;
    logic        err_clr;

    // master: the arbiter, which owns the memory bus; slave: requesters + memory
    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        input  bus_ack, bus_rdata, err_clr,
        output if_done, if_rdata, mem_done, mem_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata,
        output bus_ack, bus_rdata, err_clr,
        input  if_done, if_rdata, mem_done, mem_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between IF and MEM with bounded starvation
//            and a per-access acknowledge timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT     = 16,
    parameter int MAX_MEM_RUN = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  port
);
    localparam int c_TMO_W = $clog2(TIMEOUT);
    localparam int c_RUN_W = $clog2(MAX_MEM_RUN + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(MAX_MEM_RUN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_IF  = 2'd1,
        S_WAIT_MEM = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_RUN_W-1:0]   r_run_cnt;
    logic [c_TMO_W-1:0]   r_tmo_cnt;
    logic                 r_bus_req;
    logic                 r_bus_we;
    logic [31:0]          r_bus_addr;
    logic [31:0]          r_bus_wdata;
    logic                 r_bus_err;
    logic                 r_if_done;
    logic [31:0]          r_if_rdata;
    logic                 r_mem_done;
    logic [31:0]          r_mem_rdata;

    logic w_grant_mem;
    logic w_waiting;
    logic w_timeout;

    // MEM wins unless IF has already been passed over MAX_MEM_RUN times in a row
    assign w_grant_mem = port.mem_req && (!port.if_req || (r_run_cnt < c_RUN_MAX));
    assign w_waiting   = (r_state == S_WAIT_IF) || (r_state == S_WAIT_MEM);
    assign w_timeout   = w_waiting && !port.bus_ack && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_run_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_err   <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_done  <= 1'b0;
            r_mem_rdata <= '0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;

            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end else if (port.err_clr) begin
                r_bus_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_grant_mem) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= port.mem_we;
                        r_bus_addr  <= port.mem_addr;
                        r_bus_wdata <= port.mem_wdata;
                        r_run_cnt   <= port.if_req ? (r_run_cnt + 1'b1) : '0;
                        r_state     <= S_WAIT_MEM;
                    end else if (port.if_req) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= port.if_addr;
                        r_run_cnt   <= '0;
                        r_state     <= S_WAIT_IF;
                    end
                end

                S_WAIT_IF, S_WAIT_MEM: begin
                    if (port.bus_ack || w_timeout) begin
                        // timed-out accesses return zero data
                        r_bus_req <= 1'b0;
                        r_state   <= S_DONE;
                        if (r_state == S_WAIT_IF) begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= port.bus_ack ? port.bus_rdata : '0;
                        end else begin
                            r_mem_done  <= 1'b1;
                            r_mem_rdata <= port.bus_ack ? port.bus_rdata : '0;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign port.bus_req   = r_bus_req;
    assign port.bus_we    = r_bus_we;
    assign port.bus_addr  = r_bus_addr;
    assign port.bus_wdata = r_bus_wdata;
    assign port.bus_err   = r_bus_err;
    assign port.if_done   = r_if_done;
    assign port.if_rdata  = r_if_rdata;
    assign port.mem_done  = r_mem_done;
    assign port.mem_rdata = r_mem_rdata;
endmodule
`default_nettype wire
